// File: rtl/sign_inverter_sched.sv
// Round-robin scheduler sharing one registered sign_inverter among NUM_REQ
// requesters. An operand is accepted over req_valid/req_ready and driven on
// inv_a. The negated value is then captured from inv_b and returned with its
// requester id over res_valid/res_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/_data   per-requester operands (requester i at [i*WIDTH +: WIDTH])
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   inv_a / inv_b     to / from the shared sign_inverter (1-cycle latency)
//   res_*             result handshake: data, id, overflow flag
//   busy              high whenever the scheduler is not idle
//   op_count          completed operations, wraps at 16 bits
`timescale 1ns/1ps
module sign_inverter_sched #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         inv_a,
    input  logic [WIDTH-1:0]         inv_b,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     res_ovf,
    input  logic                     res_ready,
    output logic                     busy,
    output logic [15:0]              op_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   id_q;
    logic              ovf_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  grant_data;
    int unsigned       cand;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_grant) + off) % NUM_REQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    assign grant_data = req_data[32'(grant_idx)*WIDTH +: WIDTH];

    // Accept strobe: only the granted requester, only while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_found) state_d = WAIT;
            WAIT: state_d = CAPT;
            CAPT: state_d = HOLD;
            HOLD: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            last_grant <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            ovf_q      <= 1'b0;
            inv_a      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            res_ovf    <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        inv_a      <= grant_data;
                        id_q       <= grant_idx;
                        ovf_q      <= (grant_data == MIN_NEG);
                        last_grant <= grant_idx;
                    end
                end
                CAPT: begin
                    // inv_b now reflects the operand sampled during WAIT.
                    res_data  <= inv_b;
                    res_id    <= id_q;
                    res_ovf   <= ovf_q;
                    res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
